// File: rtl/riscv_core_dcache_axi_write_master_pkg.sv
// Shared types and AXI constants for the dcache write-through master.
package riscv_core_dcache_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEND = 2'd1,
    WR_RESP = 2'd2,
    WR_DONE = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/riscv_core_dcache_axi_write_master_if.sv
// AXI4 write-channel bundle (AW/W/B) between the dcache write master and memory.
interface riscv_core_dcache_axi_write_master_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [ID_WIDTH-1:0]   awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [63:0]           wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic [ID_WIDTH-1:0]   bid;
  logic                  bready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/riscv_core_dcache_wr_align.sv
// Moves LSB-justified store data/strobe onto the byte lanes selected by addr[2:0].
module riscv_core_dcache_wr_align (
  input  logic [2:0]  i_sh,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_strobe,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb
);
  // Bytes shifted past lane 7 are dropped; misalignment is caught upstream.
  assign o_wstrb = i_strobe << i_sh;
  assign o_wdata = i_data << {i_sh, 3'b000};
endmodule

// File: rtl/riscv_core_dcache_axi_write_master.sv
// Write-through master: one store request -> one single-beat AXI4 write, 1-cycle done.
module riscv_core_dcache_axi_write_master
  import riscv_core_dcache_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 64,
  parameter int                   DATA_WIDTH = 64,
  parameter int                   ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0]  AXI_ID     = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0] i_mem_write_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [7:0]            i_mem_write_strobe,
  input  logic [1:0]            i_size,
  output logic                  o_mem_write_done,
  output logic                  o_mem_write_error,
  riscv_core_dcache_axi_write_master_if.master axi
);

  localparam logic [1:0] ST_IDLE = WR_IDLE;
  localparam logic [1:0] ST_SEND = WR_SEND;
  localparam logic [1:0] ST_RESP = WR_RESP;
  localparam logic [1:0] ST_DONE = WR_DONE;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [1:0]            r_size;
  logic [63:0]           r_wdata;
  logic [7:0]            r_wstrb;
  logic                  r_awvalid, r_wvalid, r_bready;
  logic                  r_aw_done, r_w_done;
  logic                  r_done, r_error;

  logic [63:0] w_wdata;
  logic [7:0]  w_wstrb;
  logic        w_aw_hs, w_w_hs;
  logic        w_unused;

  riscv_core_dcache_wr_align u_align (
    .i_sh     (i_mem_write_addr[2:0]),
    .i_data   (i_mem_write_data),
    .i_strobe (i_mem_write_strobe),
    .o_wdata  (w_wdata),
    .o_wstrb  (w_wstrb)
  );

  assign w_aw_hs  = r_awvalid & axi.awready;
  assign w_w_hs   = r_wvalid & axi.wready;
  // BID is not checked and only BRESP[1] classifies the response.
  assign w_unused = ^{axi.bid, axi.bresp[0]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_awaddr  <= '0;
      r_size    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_mem_write_valid) begin
          r_awaddr  <= i_mem_write_addr;
          r_size    <= i_size;
          r_wdata   <= w_wdata;
          r_wstrb   <= w_wstrb;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Same-cycle handshakes count, so look at the flags and this cycle's hs together.
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: if (axi.bvalid) begin
          r_bready <= 1'b0;
          r_done   <= 1'b1;
          r_error  <= axi.bresp[1];
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign axi.awaddr  = r_awaddr;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, r_size};
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;

  assign o_mem_write_done  = r_done;
  assign o_mem_write_error = r_error;

endmodule
